// File: rtl/kt_pkg.sv
// Shared types and load constants for the multi-slot kitchen-timer scheduler.
// Pure declarations: no latency, no flow control.
package kt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } slot_state_t;

    typedef enum logic {
        A_IDLE = 1'b0,
        A_RING = 1'b1
    } arb_state_t;

    localparam logic [7:0] LOAD_1MIN = 8'd60;
    localparam logic [7:0] LOAD_2MIN = 8'd120;
    localparam logic [7:0] LOAD_3MIN = 8'd180;

endpackage

// File: rtl/kt_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks.
// tick is combinational from the counter; free-running, no backpressure.
module kt_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/kt_slot_scheduler.sv
// NUM_SLOTS countdown timers on a shared tick with a round-robin alarm arbiter.
// Commands act on the next edge; display is one cycle behind; no backpressure.
module kt_slot_scheduler
    import kt_pkg::*;
#(
    parameter int NUM_SLOTS   = 4,
    parameter int TICK_DIV    = 50_000_000,
    parameter int ALARM_TICKS = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [1:0]           slot_sel,
    input  logic                 mode_1min,
    input  logic                 mode_2min,
    input  logic                 mode_3min,
    output logic                 alarm,
    output logic [1:0]           alarm_slot,
    output logic [NUM_SLOTS-1:0] busy,
    output logic [1:0]           minute,
    output logic [7:0]           second
);

    localparam int RW = $clog2(ALARM_TICKS + 1);

    logic                      tick;
    logic                      sel_vld, cmd_start, mode_ok;
    logic [7:0]                load_val;
    logic [NUM_SLOTS-1:0]      expired, release_slot;
    logic [NUM_SLOTS-1:0][7:0] rem_all;

    kt_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    always_comb begin
        sel_vld   = (int'(slot_sel) < NUM_SLOTS);
        cmd_start = start & ~stop;
        mode_ok   = ({mode_3min, mode_2min, mode_1min} inside {3'b001, 3'b010, 3'b100});
        load_val  = mode_1min ? LOAD_1MIN : (mode_2min ? LOAD_2MIN : LOAD_3MIN);
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        slot_state_t st_q, st_d;
        logic [7:0]  rm_q, rm_d;
        logic        hit;

        assign hit = (slot_sel == 2'(i));

        always_comb begin
            st_d = st_q;
            rm_d = rm_q;
            case (st_q)
                IDLE: if (hit && cmd_start && mode_ok) begin
                    st_d = RUN;
                    rm_d = load_val;
                end
                RUN: if (hit && stop) begin
                    st_d = PAUSE;
                end else if (tick) begin
                    rm_d = rm_q - 8'd1;
                    if (rm_q == 8'd1) st_d = EXPIRED;
                end
                PAUSE: if (hit && stop) begin
                    st_d = IDLE;
                    rm_d = '0;
                end else if (hit && cmd_start) begin
                    st_d = RUN;
                end
                EXPIRED: if ((hit && stop) || release_slot[i]) begin
                    st_d = IDLE;
                    rm_d = '0;
                end
                default: begin
                    st_d = IDLE;
                    rm_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                st_q <= IDLE;
                rm_q <= '0;
            end else begin
                st_q <= st_d;
                rm_q <= rm_d;
            end
        end

        assign expired[i] = (st_q == EXPIRED);
        assign busy[i]    = (st_q != IDLE);
        assign rem_all[i] = rm_q;
    end

    arb_state_t          arb_q, arb_d;
    logic [1:0]          grant_q, grant_d, ptr_q, ptr_d;
    logic [RW-1:0]       ring_q, ring_d;
    logic [1:0]          rr_pick;
    logic                rr_found, ring_exit;
    logic [NUM_SLOTS-1:0] rot;
    logic [2:0]          sum;

    // Rotate so bit 0 is the slot at ptr; scanning downward leaves the nearest hit.
    always_comb begin
        rot      = NUM_SLOTS'({expired, expired} >> ptr_q);
        rr_pick  = '0;
        rr_found = 1'b0;
        sum      = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr_q} + 3'(k);
                if (sum >= 3'(NUM_SLOTS)) sum = sum - 3'(NUM_SLOTS);
                rr_pick  = sum[1:0];
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        ring_exit = (arb_q == A_RING) &&
                    ((stop && slot_sel == grant_q) || !expired[grant_q] ||
                     (tick && ring_q == RW'(ALARM_TICKS - 1)));
        release_slot = ring_exit ? (NUM_SLOTS'(1) << grant_q) : '0;

        arb_d   = arb_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        ring_d  = ring_q;
        case (arb_q)
            A_IDLE: if (rr_found) begin
                arb_d   = A_RING;
                grant_d = rr_pick;
                ring_d  = '0;
            end
            A_RING: if (ring_exit) begin
                arb_d = A_IDLE;
                ptr_d = (grant_q == 2'(NUM_SLOTS - 1)) ? 2'd0 : grant_q + 2'd1;
            end else if (tick) begin
                ring_d = ring_q + RW'(1);
            end
            default: arb_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arb_q   <= A_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            ring_q  <= '0;
        end else begin
            arb_q   <= arb_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            ring_q  <= ring_d;
        end
    end

    assign alarm      = (arb_q == A_RING);
    assign alarm_slot = alarm ? grant_q : 2'd0;

    logic [7:0] disp_rem;
    logic [1:0] minute_q, minute_d;
    logic [7:0] second_q, second_d;

    always_comb begin
        disp_rem = sel_vld ? rem_all[slot_sel] : 8'd0;
        minute_d = 2'(disp_rem / 8'd60);
        second_d = disp_rem % 8'd60;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            minute_q <= '0;
            second_q <= '0;
        end else begin
            minute_q <= minute_d;
            second_q <= second_d;
        end
    end

    assign minute = minute_q;
    assign second = second_q;

endmodule
